// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a one-entry skid buffer: registered in_ready,
// strict FIFO order, writeback mux/strobe generation and a retired-entry counter.
module mem_wb_skid_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned RET_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [RD_W-1:0]   rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              wb_en,
    output logic [RET_W-1:0]  retire_count
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_result;
        logic [RD_W-1:0]   rd;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_entry;
    logic [RET_W-1:0] retire_count_q;
    logic             accept;
    logic             drain;

    always_comb begin
        in_entry            = '0;
        in_entry.valid      = 1'b1;
        in_entry.reg_write  = reg_write_in;
        in_entry.mem_to_reg = mem_to_reg_in;
        in_entry.read_data  = read_data_in;
        in_entry.alu_result = alu_result_in;
        in_entry.rd         = rd_in;
    end

    // in_ready depends only on the skid slot, so out_ready never reaches it.
    assign in_ready = !skid_q.valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    assign out_valid      = main_q.valid;
    assign reg_write_out  = main_q.reg_write;
    assign mem_to_reg_out = main_q.mem_to_reg;
    assign read_data_out  = main_q.read_data;
    assign alu_result_out = main_q.alu_result;
    assign rd_out         = main_q.rd;
    assign wb_data_out    = main_q.mem_to_reg ? main_q.read_data : main_q.alu_result;
    assign wb_en          = drain && main_q.reg_write && (main_q.rd != '0);
    assign retire_count   = retire_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StEmpty;
            main_q         <= '0;
            skid_q         <= '0;
            retire_count_q <= '0;
        end else begin
            // A drain seen in a flush cycle still counts as retired.
            if (drain) begin
                retire_count_q <= retire_count_q + RET_W'(1);
            end
            if (flush) begin
                state_q      <= StEmpty;
                main_q.valid <= 1'b0;
                skid_q.valid <= 1'b0;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (accept) begin
                            main_q  <= in_entry;
                            state_q <= StOne;
                        end
                    end
                    StOne: begin
                        if (accept && drain) begin
                            main_q <= in_entry;
                        end else if (accept) begin
                            skid_q  <= in_entry;
                            state_q <= StTwo;
                        end else if (drain) begin
                            main_q.valid <= 1'b0;
                            state_q      <= StEmpty;
                        end
                    end
                    StTwo: begin
                        if (drain) begin
                            main_q       <= skid_q;
                            skid_q.valid <= 1'b0;
                            state_q      <= StOne;
                        end
                    end
                    default: begin
                        state_q      <= StEmpty;
                        main_q.valid <= 1'b0;
                        skid_q.valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: occupancy/scoreboard model checked every cycle,
// a table of handshake vectors, and directed multi-cycle sequences.
module tb_mem_wb_skid_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned RET_W  = 4;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic              reg_write_in, mem_to_reg_in;
    logic [DATA_W-1:0] read_data_in, alu_result_in;
    logic [RD_W-1:0]   rd_in;
    logic              in_ready, out_valid, reg_write_out, mem_to_reg_out, wb_en;
    logic [DATA_W-1:0] read_data_out, alu_result_out, wb_data_out;
    logic [RD_W-1:0]   rd_out;
    logic [RET_W-1:0]  retire_count;

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .RET_W(RET_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .reg_write_in   (reg_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .read_data_in   (read_data_in),
        .alu_result_in  (alu_result_in),
        .rd_in          (rd_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out),
        .wb_data_out    (wb_data_out),
        .wb_en          (wb_en),
        .retire_count   (retire_count)
    );

    typedef struct {
        logic              rw;
        logic              m2r;
        logic [DATA_W-1:0] rdat;
        logic [DATA_W-1:0] alu;
        logic [RD_W-1:0]   rd;
    } ent_t;

    typedef struct {
        logic              iv, ordy, fl;
        ent_t              e;
        logic              exp_ir, exp_ov, exp_wb;
        logic [DATA_W-1:0] exp_wdata;
    } vec_t;

    ent_t             q[$];
    logic [RET_W-1:0] exp_ret;
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input ent_t e);
        in_valid      = iv;
        out_ready     = ordy;
        flush         = fl;
        reg_write_in  = e.rw;
        mem_to_reg_in = e.m2r;
        read_data_in  = e.rdat;
        alu_result_in = e.alu;
        rd_in         = e.rd;
    endtask

    function automatic ent_t mk(input logic rw, input logic m2r, input logic [31:0] rdat,
                                input logic [31:0] alu, input logic [4:0] rd);
        ent_t e;
        e.rw = rw; e.m2r = m2r; e.rdat = rdat; e.alu = alu; e.rd = rd;
        return e;
    endfunction

    // One clock: model checks at the negedge, model update, then the edge.
    task automatic cycle();
        ent_t h;
        logic drn, acc;
        @(negedge clk);
        if (!reset) begin
            chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("retire_count", 64'(retire_count), 64'(exp_ret));
            drn = out_ready && (q.size() > 0);
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0) begin
                h = q[0];
                chk("rd_out", 64'(rd_out), 64'(h.rd));
                chk("reg_write_out", 64'(reg_write_out), 64'(h.rw));
                chk("mem_to_reg_out", 64'(mem_to_reg_out), 64'(h.m2r));
                chk("read_data_out", 64'(read_data_out), 64'(h.rdat));
                chk("alu_result_out", 64'(alu_result_out), 64'(h.alu));
                chk("wb_data_out", 64'(wb_data_out), 64'(h.m2r ? h.rdat : h.alu));
                chk("wb_en", 64'(wb_en), 64'(drn && h.rw && (h.rd != 0)));
            end else begin
                chk("wb_en_idle", 64'(wb_en), 64'(0));
            end
            if (drn) begin
                void'(q.pop_front());
                exp_ret++;
            end
            if (acc) q.push_back(mk(reg_write_in, mem_to_reg_in, read_data_in,
                                    alu_result_in, rd_in));
            if (flush) q.delete();
        end else begin
            q.delete();
            exp_ret = '0;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[9];
    ent_t idle, a, b, c;
    logic [RET_W-1:0] r0;

    initial begin
        idle = mk(0, 0, 0, 0, 0);
        a = mk(1, 0, 32'hA0, 32'h11, 5'd3);
        b = mk(1, 1, 32'h44, 32'hB1, 5'd4);
        c = mk(0, 0, 32'hC0, 32'h33, 5'd5);
        //        iv ordy fl  entry  ir ov wb  wdata
        vt[0] = '{0, 0, 0, idle, 1, 0, 0, 0};
        vt[1] = '{1, 0, 0, a,    1, 0, 0, 0};
        vt[2] = '{1, 0, 0, b,    1, 1, 0, 32'h11};
        vt[3] = '{1, 0, 0, c,    0, 1, 0, 32'h11};
        vt[4] = '{1, 0, 0, c,    0, 1, 0, 32'h11};
        vt[5] = '{1, 1, 0, c,    0, 1, 1, 32'h11};
        vt[6] = '{1, 1, 0, c,    1, 1, 1, 32'h44};
        vt[7] = '{0, 1, 0, idle, 1, 1, 0, 32'h33};
        vt[8] = '{0, 1, 0, idle, 1, 0, 0, 0};

        exp_ret = '0;
        reset = 1'b1;
        drive(1, 1, 0, mk(1, 0, 32'h99, 32'h98, 5'd9));
        cycle();
        cycle();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_wb_en", 64'(wb_en), 64'(0));
        chk("rst_data", 64'({read_data_out, alu_result_out}), 64'(0));
        chk("rst_ctrl", 64'({reg_write_out, mem_to_reg_out, rd_out}), 64'(0));
        chk("rst_retire", 64'(retire_count), 64'(0));
        reset = 1'b0;

        // Load with mem_to_reg, then drain it.
        drive(1, 1, 0, mk(1, 1, 32'hDEADBEEF, 32'h1234, 5'd7));
        #1 chk("l1_in_ready", 64'(in_ready), 64'(1));
        cycle();
        drive(0, 1, 0, idle);
        #1;
        chk("l1_out_valid", 64'(out_valid), 64'(1));
        chk("l1_wb_data", 64'(wb_data_out), 64'(32'hDEADBEEF));
        chk("l1_wb_en", 64'(wb_en), 64'(1));
        cycle();
        chk("l1_retire", 64'(retire_count), 64'(1));

        // Stall with A, B, C offered, then release.
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].e);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vt[i].exp_ir));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vt[i].exp_ov));
            chk($sformatf("vec%0d_wb_en", i), 64'(wb_en), 64'(vt[i].exp_wb));
            if (vt[i].exp_ov)
                chk($sformatf("vec%0d_wb_data", i), 64'(wb_data_out), 64'(vt[i].exp_wdata));
            cycle();
        end
        chk("abc_retire", 64'(retire_count), 64'(4));

        // Eight back-to-back entries.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, mk(1, i[0], $urandom, 32'(i), 5'(i + 1)));
            #1 chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'(1));
            cycle();
        end
        drive(0, 1, 0, idle);
        cycle();
        chk("stream_retire", 64'(retire_count), 64'(12));

        // Register-0 write is suppressed but still retires.
        drive(1, 1, 0, mk(1, 0, 32'hAA, 32'h5, 5'd0));
        cycle();
        drive(0, 1, 0, idle);
        #1;
        chk("r0_wb_en", 64'(wb_en), 64'(0));
        chk("r0_wb_data", 64'(wb_data_out), 64'(5));
        cycle();
        chk("r0_retire", 64'(retire_count), 64'(13));

        // Flush in TWO with an offered entry.
        drive(1, 0, 0, mk(1, 0, 1, 2, 5'd1));
        cycle();
        drive(1, 0, 0, mk(1, 0, 3, 4, 5'd2));
        cycle();
        #1 chk("two_in_ready", 64'(in_ready), 64'(0));
        drive(1, 0, 1, mk(1, 0, 5, 6, 5'd3));
        cycle();
        drive(0, 1, 0, idle);
        #1;
        chk("fl_out_valid", 64'(out_valid), 64'(0));
        chk("fl_in_ready", 64'(in_ready), 64'(1));
        cycle();
        chk("fl_out_valid2", 64'(out_valid), 64'(0));
        // Flush coinciding with a drain still counts it.
        drive(1, 0, 0, mk(0, 0, 7, 8, 5'd4));
        cycle();
        r0 = retire_count;
        drive(0, 1, 1, idle);
        cycle();
        chk("fld_out_valid", 64'(out_valid), 64'(0));
        chk("fld_retire", 64'(retire_count), 64'(r0 + 4'd1));

        // 17 drains wrap a 4-bit counter to 1.
        reset = 1'b1;
        drive(0, 0, 0, idle);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, mk(i[1], i[0], 32'(i * 3), 32'(i * 5), 5'(i)));
            cycle();
        end
        drive(0, 1, 0, idle);
        cycle();
        chk("wrap_retire", 64'(retire_count), 64'(1));

        // Reset while in TWO.
        drive(1, 0, 0, mk(1, 0, 9, 9, 5'd9));
        cycle();
        drive(1, 0, 0, mk(1, 0, 8, 8, 5'd8));
        cycle();
        reset = 1'b1;
        drive(1, 1, 0, mk(1, 0, 7, 7, 5'd7));
        cycle();
        reset = 1'b0;
        drive(0, 1, 0, idle);
        #1;
        chk("rst2_out_valid", 64'(out_valid), 64'(0));
        chk("rst2_retire", 64'(retire_count), 64'(0));
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_stage.md
MEM_WB_SKID_STAGE -- requirements
Module: mem_wb_skid_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, datapath width; RD_W, default 5, destination-register index width; RET_W, default 16, retire-counter width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: sole clock, rising edge.
- reset in 1: synchronous, active-high.
- flush in 1: discard all held entries.
- in_valid in 1: upstream entry present.
- in_ready out 1: stage can accept.
- reg_write_in in 1: entry writes the register file.
- mem_to_reg_in in 1: select memory data for writeback.
- read_data_in in DATA_W: load data.
- alu_result_in in DATA_W: ALU result.
- rd_in in RD_W: destination register.
- out_valid out 1: head entry present.
- out_ready in 1: downstream accepts the head entry.
- reg_write_out out 1: head control bit.
- mem_to_reg_out out 1: head control bit.
- read_data_out out DATA_W: head load data.
- alu_result_out out DATA_W: head ALU result.
- rd_out out RD_W: head destination.
- wb_data_out out DATA_W: selected writeback value.
- wb_en out 1: register-file write strobe.
- retire_count out RET_W: count of entries retired.

Function
REQ-003 Storage SHALL be two entries, main (head) and skid, each holding valid, reg_write, mem_to_reg, read_data, alu_result and rd.
REQ-004 Accept SHALL mean in_valid && in_ready; drain SHALL mean out_valid && out_ready.
REQ-005 in_ready SHALL equal !skid.valid; it is a pure function of state, with no combinational path from out_ready.
REQ-006 out_valid SHALL equal main.valid, and the *_out data ports SHALL present the main entry fields.
REQ-007 The state SHALL be one of EMPTY (no entry valid), ONE (main valid only) or TWO (main and skid valid).
REQ-008 EMPTY transitions: accept -> ONE with the input in main; otherwise stay EMPTY.
REQ-009 ONE transitions:
- accept && drain -> ONE, with the input replacing main.
- accept && !drain -> TWO, with the input in skid.
- !accept && drain -> EMPTY.
- otherwise hold.
REQ-010 TWO transitions: drain -> ONE, with skid copied into main and skid invalidated; otherwise hold. No accept is possible in TWO.
REQ-011 Held entries SHALL NOT change while out_ready=0, preserving stall behaviour for any stall duration.
REQ-012 Order SHALL be strict FIFO: no entry is lost, duplicated or reordered.
REQ-013 wb_data_out SHALL be combinational: mem_to_reg_out ? read_data_out : alu_result_out.
REQ-014 wb_en SHALL equal drain && reg_write_out && (rd_out != 0), so register-0 writes are suppressed.
REQ-015 retire_count SHALL increment by 1 on every drain, regardless of reg_write, and SHALL wrap from 2^RET_W-1 to 0.
REQ-016 flush=1 at a rising edge SHALL clear both valid bits, so the next state is EMPTY.
- flush has priority over accept and drain in that cycle.
- The drain presented in a flush cycle still increments retire_count.
- Data fields MAY hold stale values.
REQ-017 Latency SHALL be one cycle from accept into EMPTY to out_valid=1.
REQ-018 Sustained throughput SHALL be one entry per cycle while out_ready=1.

Reset
REQ-019 reset=1 at a rising edge SHALL force the following, with priority over flush, accept and drain:
- Both valid bits, all stored data and control fields, and retire_count to 0.
- State to EMPTY.
REQ-020 While reset is held, the outputs SHALL read:
- out_valid=0, wb_en=0, and all data outputs 0.
- in_ready=1 after the first reset edge.
- Inputs presented during reset cycles are not captured.

Verification
REQ-021 Reset, then accept {reg_write=1, mem_to_reg=1, read_data=0xDEADBEEF, rd=7} with out_ready=1 -> next cycle out_valid=1, wb_data_out=0xDEADBEEF, wb_en=1, retire_count=1 after that edge.
REQ-022 out_ready=0, then offer A, B, C on consecutive cycles -> A in main, B in skid, in_ready=0, C held upstream; raise out_ready -> A, B, C retire in order with no gaps after the first.
REQ-023 Back-to-back stream of 8 entries with out_ready=1 -> 8 consecutive drains, in_ready stays 1, retire_count=8.
REQ-024 Entry {reg_write=1, rd=0, alu_result=0x5} drained -> wb_en=0, wb_data_out=0x5, retire_count increments.
REQ-025 State TWO, then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered entry is not captured.
REQ-026 RET_W=4, 17 drains -> retire_count=1; then reset mid-stream in state TWO -> out_valid=0 and retire_count=0 on the next cycle.
